// File: rtl/regfile_wb_arbiter_if.sv
// Write-back bus between the execution units and the register-file port 0.
// Handshake: a requester raises req_valid[i] and holds addr/data stable; a transfer
// happens on any cycle where req_valid[i] and req_ready[i] are both 1.
interface regfile_wb_arbiter_if #(
    parameter int N_REQ   = 3,
    parameter int N_REGS  = 32,
    parameter int R_WIDTH = 32
);
    localparam int W_ADDR = $clog2(N_REGS);

    logic [N_REQ-1:0]                req_valid;
    logic [N_REQ-1:0]                req_ready;
    logic [N_REQ-1:0][W_ADDR-1:0]    req_addr;
    logic [N_REQ-1:0][R_WIDTH-1:0]   req_data;
    logic                            rf_write;
    logic [W_ADDR-1:0]               rf_addr;
    logic [R_WIDTH-1:0]              rf_data;
    logic                            rf_addr_error;

    modport master (
        output req_valid, req_addr, req_data, rf_addr_error,
        input  req_ready, rf_write, rf_addr, rf_data
    );

    modport slave (
        input  req_valid, req_addr, req_data, rf_addr_error,
        output req_ready, rf_write, rf_addr, rf_data
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin write-back arbiter for register-file port 0, with pipeline hold
// and a sticky error state driven by address errors returned from the register file.
module regfile_wb_arbiter #(
    parameter int N_REQ   = 3,
    parameter int N_REGS  = 32,
    parameter int R_WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    regfile_wb_arbiter_if.slave        bus,
    input  logic                       stall,
    output logic                       err_irq,
    output logic [$clog2(N_REQ)-1:0]   err_src,
    input  logic                       err_clear,
    output logic [1:0]                 fsm_state
);
    localparam int W_ADDR = $clog2(N_REGS);
    localparam int SW     = $clog2(N_REQ);

    typedef enum logic [1:0] {RUN = 2'd0, HOLD = 2'd1, ERROR = 2'd2} state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   rr_ptr;
    logic [SW-1:0]   win;
    logic            found;
    logic            xfer;
    logic [SW-1:0]   last_src;
    logic            pend_valid;
    logic [SW-1:0]   pend_src;
    logic            err_evt;

    // Two passes: indices below rr_ptr first, then indices at/above rr_ptr overwrite,
    // so the final pick is the first valid requester searching upward from rr_ptr.
    always_comb begin
        win   = '0;
        found = 1'b0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (bus.req_valid[i] && (i < int'(rr_ptr))) begin
                win   = SW'(i);
                found = 1'b1;
            end
        end
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (bus.req_valid[i] && (i >= int'(rr_ptr))) begin
                win   = SW'(i);
                found = 1'b1;
            end
        end
    end

    assign xfer          = found && (state_q == RUN) && !stall && !rst;
    assign bus.req_ready = xfer ? (N_REQ'(1) << win) : '0;

    // The error response belongs to the write issued in the previous cycle.
    assign err_evt   = pend_valid && bus.rf_addr_error;
    assign fsm_state = state_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (stall)     state_d = HOLD;
            HOLD:    if (!stall)    state_d = RUN;
            ERROR:   if (err_clear) state_d = RUN;
            default:                state_d = RUN;
        endcase
        if (err_evt) state_d = ERROR;
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= RUN;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr       <= '0;
            bus.rf_write <= 1'b0;
            bus.rf_addr  <= '0;
            bus.rf_data  <= '0;
            last_src     <= '0;
            pend_valid   <= 1'b0;
            pend_src     <= '0;
            err_irq      <= 1'b0;
            err_src      <= '0;
        end else begin
            bus.rf_write <= xfer && (bus.req_addr[win] != W_ADDR'(0));
            pend_valid   <= bus.rf_write;
            pend_src     <= last_src;
            if (xfer) begin
                bus.rf_addr <= bus.req_addr[win];
                bus.rf_data <= bus.req_data[win];
                last_src    <= win;
                rr_ptr      <= (win == SW'(N_REQ - 1)) ? '0 : win + SW'(1);
            end
            if (err_evt && (state_q != ERROR)) begin
                err_irq <= 1'b1;
                err_src <= pend_src;
            end else if ((state_q == ERROR) && (state_d == RUN)) begin
                err_irq <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: grants and status checked inline,
// register-file writes checked by a monitor against an expected-write queue.
module tb_regfile_wb_arbiter;
    logic       clk;
    logic       rst;
    logic       stall;
    logic       err_clear;
    logic       err_irq;
    logic [1:0] err_src;
    logic [1:0] fsm_state;

    int n_checks = 0;
    int n_fail   = 0;

    logic [36:0] exp_q[$];
    logic [36:0] exp_word;

    regfile_wb_arbiter_if #(.N_REQ(3), .N_REGS(32), .R_WIDTH(32)) bus ();

    regfile_wb_arbiter #(.N_REQ(3), .N_REGS(32), .R_WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .stall     (stall),
        .err_irq   (err_irq),
        .err_src   (err_src),
        .err_clear (err_clear),
        .fsm_state (fsm_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [1:0] i, input logic v, input logic [4:0] a, input logic [31:0] d);
        bus.req_valid[i] = v;
        bus.req_addr[i]  = a;
        bus.req_data[i]  = d;
    endtask

    task automatic push(input logic [4:0] a, input logic [31:0] d);
        exp_q.push_back({a, d});
    endtask

    always @(negedge clk) begin
        if (bus.rf_write === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL wb_unexpected: got write addr=%0h data=%0h, required no write",
                         bus.rf_addr, bus.rf_data);
            end else begin
                exp_word = exp_q.pop_front();
                check("wb_addr", 64'(bus.rf_addr), 64'(exp_word[36:32]));
                check("wb_data", 64'(bus.rf_data), 64'(exp_word[31:0]));
            end
        end
    end

    initial begin
        rst = 1'b1; stall = 1'b0; err_clear = 1'b0;
        bus.rf_addr_error = 1'b0;
        bus.req_valid = '0; bus.req_addr = '0; bus.req_data = '0;
        step(); step();

        // Requests present while reset is held must not be granted.
        set_req(2'd0, 1'b1, 5'd1, 32'h1111_1111);
        set_req(2'd1, 1'b1, 5'd2, 32'h2222_2222);
        set_req(2'd2, 1'b1, 5'd3, 32'h3333_3333);
        #1 check("ready_in_reset", 64'(bus.req_ready), 64'(0));

        // Round-robin across all three requesters.
        step(); rst = 1'b0; #1;
        check("rst_rf_write", 64'(bus.rf_write), 64'(0));
        check("rst_rf_addr", 64'(bus.rf_addr), 64'(0));
        check("rst_rf_data", 64'(bus.rf_data), 64'(0));
        check("rst_err_irq", 64'(err_irq), 64'(0));
        check("rst_err_src", 64'(err_src), 64'(0));
        check("rst_state", 64'(fsm_state), 64'(0));
        check("rr_grant0", 64'(bus.req_ready), 64'(3'b001)); push(5'd1, 32'h1111_1111);
        step(); #1 check("rr_grant1", 64'(bus.req_ready), 64'(3'b010)); push(5'd2, 32'h2222_2222);
        step(); #1 check("rr_grant2", 64'(bus.req_ready), 64'(3'b100)); push(5'd3, 32'h3333_3333);
        step(); bus.req_valid = '0; #1 check("idle_ready", 64'(bus.req_ready), 64'(0));

        // Write to x0 is accepted but dropped.
        step(); set_req(2'd1, 1'b1, 5'd0, 32'hDEAD_BEEF);
        #1 check("x0_ready", 64'(bus.req_ready), 64'(3'b010));
        step(); bus.req_valid = '0;
        #1 check("x0_no_write", 64'(bus.rf_write), 64'(0));

        // Stall for two cycles; grant once the arbiter is back in RUN.
        step(); stall = 1'b1; set_req(2'd2, 1'b1, 5'd7, 32'h0000_0077);
        #1 check("stall_ready_a", 64'(bus.req_ready), 64'(0));
        step(); #1 check("stall_ready_b", 64'(bus.req_ready), 64'(0));
        check("hold_state", 64'(fsm_state), 64'(1));
        step(); stall = 1'b0; #1 check("hold_exit_ready", 64'(bus.req_ready), 64'(0));
        step(); #1 check("post_stall_grant", 64'(bus.req_ready), 64'(3'b100)); push(5'd7, 32'h0000_0077);

        // Address error after a write from requester 2; a transfer in the same cycle still writes.
        step(); set_req(2'd2, 1'b1, 5'd9, 32'h0000_0099);
        #1 check("err_setup_grant", 64'(bus.req_ready), 64'(3'b100)); push(5'd9, 32'h0000_0099);
        step(); bus.req_valid = '0; #1 check("err_pre_irq", 64'(err_irq), 64'(0));
        step(); bus.rf_addr_error = 1'b1; set_req(2'd0, 1'b1, 5'd4, 32'h0000_0044);
        #1 check("err_cycle_grant", 64'(bus.req_ready), 64'(3'b001)); push(5'd4, 32'h0000_0044);
        step(); bus.rf_addr_error = 1'b0; bus.req_valid = '0; set_req(2'd1, 1'b1, 5'd6, 32'h0000_0066);
        #1 check("err_irq_set", 64'(err_irq), 64'(1));
        check("err_src", 64'(err_src), 64'(2));
        check("err_state", 64'(fsm_state), 64'(2));
        check("err_ready_a", 64'(bus.req_ready), 64'(0));
        step(); #1 check("err_ready_b", 64'(bus.req_ready), 64'(0));
        step(); err_clear = 1'b1; #1 check("err_ready_clr", 64'(bus.req_ready), 64'(0));
        check("err_irq_held", 64'(err_irq), 64'(1));
        step(); err_clear = 1'b0; #1 check("resume_state", 64'(fsm_state), 64'(0));
        check("err_irq_cleared", 64'(err_irq), 64'(0));
        check("resume_grant", 64'(bus.req_ready), 64'(3'b010)); push(5'd6, 32'h0000_0066);

        // Reset discards pending work and returns the pointer to requester 0.
        step(); bus.req_valid = '0; set_req(2'd0, 1'b1, 5'd10, 32'h0000_00A0);
        #1 check("pre_rst_grant", 64'(bus.req_ready), 64'(3'b001)); push(5'd10, 32'h0000_00A0);
        step(); rst = 1'b1;
        set_req(2'd0, 1'b1, 5'd11, 32'h0000_00B0);
        set_req(2'd1, 1'b1, 5'd12, 32'h0000_00B1);
        set_req(2'd2, 1'b1, 5'd13, 32'h0000_00B2);
        #1 check("rst_ready", 64'(bus.req_ready), 64'(0));
        step(); rst = 1'b0;
        #1 check("rst_discard", 64'(bus.rf_write), 64'(0));
        check("rst_ptr_grant", 64'(bus.req_ready), 64'(3'b001)); push(5'd11, 32'h0000_00B0);

        // Requester 0 continuous, requester 1 competing: strict alternation.
        step(); set_req(2'd2, 1'b0, 5'd13, 32'h0000_00B2);
        #1 check("alt_grant1", 64'(bus.req_ready), 64'(3'b010)); push(5'd12, 32'h0000_00B1);
        step(); #1 check("alt_grant0", 64'(bus.req_ready), 64'(3'b001)); push(5'd11, 32'h0000_00B0);
        step(); #1 check("alt_grant1b", 64'(bus.req_ready), 64'(3'b010)); push(5'd12, 32'h0000_00B1);
        step(); #1 check("alt_grant0b", 64'(bus.req_ready), 64'(3'b001)); push(5'd11, 32'h0000_00B0);
        step(); bus.req_valid = '0;
        repeat (3) step();

        check("sb_drained", 64'(exp_q.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
